// File: rtl/nand_i8_vector_checker.sv
// Stimulus/checker stage around an 8-bit NAND DUT: LFSR operands out,
// delayed golden ~(a&b) compared against the DUT result y.
//
// Parameters:
//   NUM_VEC   vectors issued (1..255)
//   LATENCY   DUT latency in cycles (0..8), 0 = combinational DUT
//   SEED_A/B  LFSR seeds, a zero seed is replaced by 8'h01
// Ports:
//   clock      sole clock, posedge
//   reset      synchronous active-high, beats hold
//   hold       freezes all state for the cycle
//   y          DUT result
//   a, b       operands to the DUT
//   fail       sticky mismatch flag
//   finish     sticky completion flag
//   err_count  saturating mismatch count
//   vec_idx    index of the vector currently on a/b
module nand_i8_vector_checker #(
   parameter int unsigned NUM_VEC = 16,
   parameter int unsigned LATENCY = 0,
   parameter logic [7:0]  SEED_A  = 8'h0F,
   parameter logic [7:0]  SEED_B  = 8'h0F
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       hold,
   input  logic [7:0] y,
   output logic [7:0] a,
   output logic [7:0] b,
   output logic       fail,
   output logic       finish,
   output logic [7:0] err_count,
   output logic [7:0] vec_idx
);

   // An all-zero seed would lock the LFSR at zero.
   localparam logic [7:0] SEED_A_EFF =
      (SEED_A == 8'h00) ? 8'h01 : SEED_A;
   localparam logic [7:0] SEED_B_EFF =
      (SEED_B == 8'h00) ? 8'h01 : SEED_B;
   localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);
   localparam int unsigned DEPTH = (LATENCY > 0) ? LATENCY : 1;
   localparam logic [3:0] DRAIN_LAST = 4'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
   endfunction

   state_t     state_q, state_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] idx_q, idx_d;
   logic       fail_q, fail_d;
   logic [7:0] err_q, err_d;
   logic [3:0] drain_q, drain_d;

   logic       issue_vld;
   logic [7:0] issue_exp;
   logic       cmp_vld;
   logic [7:0] cmp_exp;
   logic       mismatch;

   // Every RUN cycle presents exactly one vector.
   assign issue_vld = (state_q == ST_RUN);
   assign issue_exp = ~(a_q & b_q);

   generate
      if (LATENCY > 0) begin : g_dly
         logic [DEPTH-1:0] vld_q, vld_d;
         logic [7:0]       exp_q [DEPTH];
         logic [7:0]       exp_d [DEPTH];

         // Golden pipe advances only when the checker advances.
         always_comb begin
            vld_d = vld_q;
            exp_d = exp_q;
            if (!hold) begin
               vld_d[0] = issue_vld;
               exp_d[0] = issue_exp;
               for (int i = 1; i < int'(DEPTH); i++) begin
                  vld_d[i] = vld_q[i-1];
                  exp_d[i] = exp_q[i-1];
               end
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               vld_q <= '0;
               exp_q <= '{default: 8'h00};
            end else begin
               vld_q <= vld_d;
               exp_q <= exp_d;
            end
         end

         assign cmp_vld = vld_q[DEPTH-1];
         assign cmp_exp = exp_q[DEPTH-1];
      end else begin : g_comb
         assign cmp_vld = issue_vld;
         assign cmp_exp = issue_exp;
      end
   endgenerate

   // A slot landing in a hold cycle stays in the pipe and is checked later.
   assign mismatch = !hold && cmp_vld && (state_q != ST_DONE) &&
                     (y != cmp_exp);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      fail_d  = fail_q;
      err_d   = err_q;
      drain_d = drain_q;
      if (!hold) begin
         if (mismatch) begin
            fail_d = 1'b1;
            if (err_q != 8'hFF) begin
               err_d = err_q + 8'd1;
            end
         end
         unique case (state_q)
            ST_RUN: begin
               if (idx_q == LAST_IDX) begin
                  if (LATENCY == 0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_DRAIN;
                     drain_d = 4'd0;
                  end
               end else begin
                  a_d   = lfsr_step(a_q);
                  b_d   = lfsr_step(b_q);
                  idx_d = idx_q + 8'd1;
               end
            end
            // Last slot reaches the compare after LATENCY drain cycles.
            ST_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  drain_d = drain_q + 4'd1;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_RUN;
         a_q     <= SEED_A_EFF;
         b_q     <= SEED_B_EFF;
         idx_q   <= 8'd0;
         fail_q  <= 1'b0;
         err_q   <= 8'd0;
         drain_q <= 4'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
         drain_q <= drain_d;
      end
   end

`ifdef NAND_I8_CHK_VERBOSE
   // Optional mismatch trace for simulation.
   always @(posedge clock) begin
      if (!reset && mismatch) begin
         $display("~~FAIL~~");
      end
   end
`endif

   assign a         = a_q;
   assign b         = b_q;
   assign fail      = fail_q;
   assign finish    = (state_q == ST_DONE);
   assign err_count = err_q;
   assign vec_idx   = idx_q;

endmodule

// File: tb/tb_nand_i8_vector_checker.sv
// Directed bench for nand_i8_vector_checker: several configurations
// driven by small NAND models, checked against hand-computed values.
module tb_nand_i8_vector_checker;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // u1: 1 vector, combinational
   logic [7:0] a1, b1, y1, e1, i1;
   logic       f1, d1;
   assign y1 = ~(a1 & b1);
   nand_i8_vector_checker #(.NUM_VEC(1), .LATENCY(0)) u1 (
      .clock(clk), .reset(rst), .hold(1'b0), .y(y1), .a(a1), .b(b1),
      .fail(f1), .finish(d1), .err_count(e1), .vec_idx(i1));

   // u2: 3 vectors, combinational
   logic [7:0] a2, b2, y2, e2, i2;
   logic       f2, d2;
   assign y2 = ~(a2 & b2);
   nand_i8_vector_checker #(.NUM_VEC(3), .LATENCY(0)) u2 (
      .clock(clk), .reset(rst), .hold(1'b0), .y(y2), .a(a2), .b(b2),
      .fail(f2), .finish(d2), .err_count(e2), .vec_idx(i2));

   // u3: 3 vectors, 2-cycle DUT
   logic [7:0] a3, b3, y3, e3, i3, p3_1, p3_2;
   logic       f3, d3;
   always @(posedge clk) begin
      p3_1 <= ~(a3 & b3);
      p3_2 <= p3_1;
   end
   assign y3 = p3_2;
   nand_i8_vector_checker #(.NUM_VEC(3), .LATENCY(2)) u3 (
      .clock(clk), .reset(rst), .hold(1'b0), .y(y3), .a(a3), .b(b3),
      .fail(f3), .finish(d3), .err_count(e3), .vec_idx(i3));

   // u4: as u3, y killed on one cycle
   logic [7:0] a4, b4, y4, e4, i4, p4_1, p4_2;
   logic       f4, d4, kill4;
   always @(posedge clk) begin
      p4_1 <= ~(a4 & b4);
      p4_2 <= p4_1;
   end
   assign y4 = kill4 ? 8'h00 : p4_2;
   nand_i8_vector_checker #(.NUM_VEC(3), .LATENCY(2)) u4 (
      .clock(clk), .reset(rst), .hold(1'b0), .y(y4), .a(a4), .b(b4),
      .fail(f4), .finish(d4), .err_count(e4), .vec_idx(i4));

   // u5: 8 vectors, hold and error injection
   logic [7:0] a5, b5, y5, e5, i5;
   logic       f5, d5, hold5, inj5;
   assign y5 = ~(a5 & b5) ^ {7'd0, inj5};
   nand_i8_vector_checker #(.NUM_VEC(8), .LATENCY(0)) u5 (
      .clock(clk), .reset(rst), .hold(hold5), .y(y5), .a(a5), .b(b5),
      .fail(f5), .finish(d5), .err_count(e5), .vec_idx(i5));

   // u6: 255 vectors, y stuck at zero, seed B zero
   logic [7:0] a6, b6, e6, i6;
   logic       f6, d6;
   nand_i8_vector_checker #(.NUM_VEC(255), .LATENCY(0),
                            .SEED_A(8'h0F), .SEED_B(8'h00)) u6 (
      .clock(clk), .reset(rst), .hold(1'b0), .y(8'h00), .a(a6), .b(b6),
      .fail(f6), .finish(d6), .err_count(e6), .vec_idx(i6));

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      hold5 = 1'b0;
      inj5  = 1'b0;
      kill4 = 1'b0;
      @(negedge clk);
      do_reset();

      // Phase 1: u1..u4 and u6 from one reset
      for (int c = 0; c <= 256; c++) begin
         kill4 = (c == 3);
         if (c == 0) begin
            chk("u1_rst_a", a1, 8'h0F);
            chk("u1_rst_b", b1, 8'h0F);
            chk("u1_rst_idx", i1, 8'h00);
            chk("u1_rst_fail", f1, 1'b0);
            chk("u1_rst_fin", d1, 1'b0);
            chk("u1_rst_err", e1, 8'h00);
            chk("u2_c0_a", a2, 8'h0F);
            chk("u6_rst_a", a6, 8'h0F);
            chk("u6_rst_b_zero_seed", b6, 8'h01);
         end
         if (c == 1) begin
            chk("u1_fin", d1, 1'b1);
            chk("u1_fail", f1, 1'b0);
            chk("u1_err", e1, 8'h00);
            chk("u2_c1_a", a2, 8'hBF);
            chk("u2_c1_b", b2, 8'hBF);
            chk("u2_c1_idx", i2, 8'h01);
            chk("u6_c1_b", b6, 8'hB8);
         end
         if (c == 2) begin
            chk("u2_c2_a", a2, 8'hE7);
            chk("u2_c2_idx", i2, 8'h02);
            chk("u2_c2_fin", d2, 1'b0);
         end
         if (c == 3) begin
            chk("u2_fin", d2, 1'b1);
            chk("u2_fail", f2, 1'b0);
            chk("u2_c3_a_frozen", a2, 8'hE7);
            chk("u3_c3_fin", d3, 1'b0);
            chk("u4_c3_fail", f4, 1'b0);
         end
         if (c == 4) begin
            chk("u3_c4_fail", f3, 1'b0);
            chk("u3_c4_fin", d3, 1'b0);
            chk("u4_c4_fail", f4, 1'b1);
            chk("u4_c4_err", e4, 8'h01);
            chk("u4_c4_fin", d4, 1'b0);
         end
         if (c == 5) begin
            chk("u3_fin", d3, 1'b1);
            chk("u3_fail", f3, 1'b0);
            chk("u3_err", e3, 8'h00);
            chk("u4_fin", d4, 1'b1);
            chk("u4_err", e4, 8'h01);
            chk("u4_fail_sticky", f4, 1'b1);
         end
         if (c == 254) begin
            chk("u6_c254_err", e6, 8'd254);
            chk("u6_c254_idx", i6, 8'd254);
            chk("u6_c254_fin", d6, 1'b0);
         end
         if (c == 255) begin
            chk("u6_c255_err", e6, 8'd255);
            chk("u6_c255_fin", d6, 1'b1);
            chk("u6_c255_fail", f6, 1'b1);
         end
         if (c == 256) begin
            chk("u6_c256_err", e6, 8'd255);
         end
         @(negedge clk);
      end
      kill4 = 1'b0;

      // Phase 2: hold for 3 cycles mid-run
      do_reset();
      for (int c = 0; c <= 12; c++) begin
         hold5 = (c >= 2 && c <= 4);
         if (c == 0) chk("h_c0_a", a5, 8'h0F);
         if (c == 1) chk("h_c1_a", a5, 8'hBF);
         if (c == 2) chk("h_c2_idx", i5, 8'h02);
         if (c == 4) chk("h_c4_a", a5, 8'hE7);
         if (c == 5) begin
            chk("h_c5_a", a5, 8'hE7);
            chk("h_c5_idx", i5, 8'h02);
         end
         if (c == 6) begin
            chk("h_c6_a", a5, 8'hCB);
            chk("h_c6_b", b5, 8'hCB);
            chk("h_c6_idx", i5, 8'h03);
         end
         if (c == 10) chk("h_c10_fin", d5, 1'b0);
         if (c == 11) begin
            chk("h_c11_fin", d5, 1'b1);
            chk("h_c11_err", e5, 8'h00);
            chk("h_c11_fail", f5, 1'b0);
         end
         @(negedge clk);
      end
      hold5 = 1'b0;

      // Phase 3: reset mid-run with fail set, hold high
      do_reset();
      for (int c = 0; c < 5; c++) begin
         inj5 = (c == 0);
         @(negedge clk);
      end
      inj5 = 1'b0;
      chk("r_c5_idx", i5, 8'h05);
      chk("r_c5_a", a5, 8'hD6);
      chk("r_c5_fail", f5, 1'b1);
      chk("r_c5_err", e5, 8'h01);
      rst   = 1'b1;
      hold5 = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      hold5 = 1'b0;
      chk("r_fail", f5, 1'b0);
      chk("r_err", e5, 8'h00);
      chk("r_a", a5, 8'h0F);
      chk("r_b", b5, 8'h0F);
      chk("r_idx", i5, 8'h00);
      chk("r_fin", d5, 1'b0);
      @(negedge clk);
      chk("r_next_a", a5, 8'hBF);
      chk("r_next_idx", i5, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nand_i8_vector_checker.md
Name: nand_i8_vector_checker

Overview:
- Self-checking stimulus and checker stage wrapped around an 8-bit NAND DUT (a, b -> y).
- Generates NUM_VEC operand pairs from two LFSRs and drives them to the DUT.
- Delays the golden result ~(a & b) by LATENCY cycles and compares it against the DUT's y.
- Reports sticky fail, finish and an error count; generalizes the single-vector benches to multi-vector, pipelined DUTs.

Parameters:
- NUM_VEC, 16, number of vectors issued; legal range 1..255.
- LATENCY, 0, cycles from a/b presentation until y is valid; 0 = combinational DUT; legal range 0..8.
- SEED_A, 8'h0F, initial LFSR state for a; 0 is replaced by 8'h01.
- SEED_B, 8'h0F, initial LFSR state for b; 0 is replaced by 8'h01.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; takes priority over all other inputs.
- hold  in  1  when high, freezes all internal state and outputs for that cycle.
- y  in  8  DUT result.
- a  out  8  operand A to DUT.
- b  out  8  operand B to DUT.
- fail  out  1  sticky mismatch flag.
- finish  out  1  sticky completion flag.
- err_count  out  8  saturating mismatch count.
- vec_idx  out  8  index of the vector currently on a/b.

Behaviour:
- Reset values: a=SEED_A, b=SEED_B (after the zero substitution), vec_idx=0, fail=0, finish=0, err_count=0, delay line valid bits all 0, state=RUN.
- LFSR, 8-bit Galois, applied independently to a and b: next = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00).
- Issue: in the first non-hold cycle after reset (cycle 0), vector 0 is on a/b.
  - On each non-hold edge in RUN with vec_idx < NUM_VEC-1: a, b step their LFSRs and vec_idx increments.
  - Once vec_idx = NUM_VEC-1, a/b/vec_idx hold their values.
- Golden path:
  - exp = ~(a & b), tagged valid for each of the NUM_VEC issue cycles.
  - exp and valid pass through a delay line LATENCY stages deep.
  - With LATENCY=0 the compare is in the same cycle against the current a/b.
- Compare: in any non-hold cycle where the delayed valid is 1 and y != delayed exp:
  - fail <= 1 at the next edge;
  - err_count <= err_count+1, saturating at 8'hFF;
  - $display("~~FAIL~~") in simulation only.
- States:
  - RUN: issuing vectors; moves to DRAIN on the edge that issues the last vector's compare slot into the pipe.
  - DRAIN: waits for the delay line to empty; skipped when LATENCY=0.
  - DONE: entered on the edge after the last compare. Sets finish=1. Compares stop and outputs freeze until reset.
- Timing: finish is first seen high in cycle NUM_VEC+LATENCY, counted from cycle 0.
- hold:
  - Stalls the LFSRs, vec_idx, the delay line, the compare and the FSM.
  - Has no effect on fail/finish already set.
  - A compare whose slot falls in a hold cycle is deferred, not dropped.
- Simultaneous events:
  - A mismatch on the final compare sets fail and finish on the same edge.
  - reset with hold high still resets.
- Reset mid-run returns everything to reset values; the sequence restarts from vector 0 on the next cycle.
- fail and finish never deassert except by reset.

Test Plan:
- NUM_VEC=1, LATENCY=0, DUT correct: a=b=8'h0F in cycle 0, y=8'hF0 -> finish=1 in cycle 1, fail=0, err_count=0.
- NUM_VEC=3, LATENCY=0: a/b sequence 0F, BF, E7 -> expected 8'hF0, 8'h40, 8'h18. Correct DUT -> fail=0; finish rises in cycle 3.
- NUM_VEC=3, LATENCY=2, DUT output delayed 2 cycles -> no mismatch; finish rises in cycle 5.
- Same configuration but y forced to 8'h00 on vector 1's compare cycle -> fail=1 from the following cycle, err_count=1, finish still in cycle 5.
- hold high for 3 cycles mid-run -> a/b/vec_idx/finish timing shift by exactly 3 cycles; err_count unchanged.
- reset pulsed mid-run (vec_idx=5) with fail=1 -> next cycle fail=0, err_count=0, a=b=8'h0F, vec_idx=0.
- y stuck at 8'h00 for NUM_VEC=255, using mismatching seeds -> err_count=255 counted without saturating early; sticky fail.
